// File: rtl/matrix_mac_sequencer.sv
// matrix_mac_sequencer
//   Control FSM that walks one MAC datapath through a square matrix
//   product C = A x B, one output element (i,j) at a time:
//   clear accumulator, stream DIM operand address pairs, drain the RAM
//   latency, write the result.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start, abort   host request (sampled only in IDLE) / synchronous cancel
//   busy, done     host status; done is a one-cycle pulse after the last write
//   mem_rd         read strobe to the A and B RAMs (1-cycle read latency)
//   a_addr,b_addr  operand addresses {i,k} and {k,j}
//   mac_clear      clears the MAC accumulator
//   mac_enable     MAC accumulates the current RAM output pair
//   res_we         write strobe to the C RAM
//   res_addr       result address {i,j}, valid while res_we=1
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; busy=0
// CLEAR | one cycle, mac_clear=1, k reset
// RUN   | DIM cycles, mem_rd=1, one operand pair per cycle, k counts up
// DRAIN | one cycle, RAM returns the k=DIM-1 pair, mac_enable still 1
// WRITE | one cycle, res_we=1, advance (i,j) or finish
// DONE  | one cycle, done=1, busy=0

module matrix_mac_sequencer #(
  parameter int IDX_WIDTH  = 2,
  parameter int ADDR_WIDTH = 2 * IDX_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic                  res_we,
  output logic [ADDR_WIDTH-1:0] res_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Last index value; counters wrap naturally on IDX_WIDTH bits.
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = '1;

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] i_q, j_q, k_q;
  logic [IDX_WIDTH-1:0] i_n, j_n, k_n;

  // Next values of the registered outputs.
  logic                  busy_n;
  logic                  done_n;
  logic                  mem_rd_n;
  logic                  mac_clear_n;
  logic                  res_we_n;
  logic [ADDR_WIDTH-1:0] a_addr_n;
  logic [ADDR_WIDTH-1:0] b_addr_n;
  logic [ADDR_WIDTH-1:0] res_addr_n;

  // mem_rd delayed one cycle to line up with the RAM read data.
  logic rd_q;

  assign mac_enable = rd_q;

  // ---------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mac_clear <= 1'b0;
      res_we    <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      res_addr  <= '0;
      rd_q      <= 1'b0;
    end else begin
      state     <= state_n;
      i_q       <= i_n;
      j_q       <= j_n;
      k_q       <= k_n;
      busy      <= busy_n;
      done      <= done_n;
      mem_rd    <= mem_rd_n;
      mac_clear <= mac_clear_n;
      res_we    <= res_we_n;
      a_addr    <= a_addr_n;
      b_addr    <= b_addr_n;
      res_addr  <= res_addr_n;
      // An abort must not let a read already in flight accumulate.
      rd_q      <= abort ? 1'b0 : mem_rd;
    end
  end

  // ---------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------
  always_comb begin
    state_n = state;
    i_n     = i_q;
    j_n     = j_q;
    k_n     = k_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          i_n     = '0;
          j_n     = '0;
        end
      end

      S_CLEAR: begin
        k_n     = '0;
        state_n = S_RUN;
      end

      S_RUN: begin
        k_n = k_q + 1'b1;
        if (k_q == IDX_LAST) begin
          state_n = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_n = S_WRITE;
      end

      S_WRITE: begin
        if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) begin
          state_n = S_DONE;
        end else begin
          j_n = j_q + 1'b1;
          if (j_q == IDX_LAST) begin
            i_n = i_q + 1'b1;
          end
          state_n = S_CLEAR;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_n = S_IDLE;
      i_n     = i_q;
      j_n     = j_q;
      k_n     = k_q;
    end
  end

  // ---------------------------------------------------------------
  // Output logic: decoded from the next state so the registered
  // strobes are aligned with the state they belong to.
  // ---------------------------------------------------------------
  always_comb begin
    busy_n      = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n      = (state_n == S_DONE);
    mem_rd_n    = (state_n == S_RUN);
    mac_clear_n = (state_n == S_CLEAR);
    res_we_n    = (state_n == S_WRITE);

    // Addresses hold their last value while their strobe is low.
    a_addr_n   = a_addr;
    b_addr_n   = b_addr;
    res_addr_n = res_addr;

    // Row-major flat address: {row,col} == row*DIM + col.
    if (mem_rd_n) begin
      a_addr_n = {i_n, k_n};
      b_addr_n = {k_n, j_n};
    end
    if (res_we_n) begin
      res_addr_n = {i_n, j_n};
    end
  end

endmodule

// File: doc/matrix_mac_sequencer.md
Name: matrix_mac_sequencer

Overview:
- Control FSM that sequences one matrix_mac_unit through a full square matrix product C = A x B.
- For each output element (i,j) it clears the accumulator, streams operand addresses for A row i and B column j to two synchronous-read operand memories, pulses MAC enable in step with the returned data, then issues a result-memory write.
- Sits between the host start/done interface, the A/B operand RAMs, the MAC datapath and the C result RAM.

Parameters:
- IDX_WIDTH, 2, bits per row/column index. DIM = 2**IDX_WIDTH; default is 4x4 matrices.
- ADDR_WIDTH, 2*IDX_WIDTH, flat element address width, row-major: addr = row*DIM + col.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a product; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle with no done.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse after the final result write.
- mem_rd  out  1  read strobe to the A and B RAMs (1-cycle read latency).
- a_addr  out  ADDR_WIDTH  A element address, i*DIM+k.
- b_addr  out  ADDR_WIDTH  B element address, k*DIM+j.
- mac_clear  out  1  clears the MAC accumulator.
- mac_enable  out  1  MAC accumulates the current RAM output pair.
- res_we  out  1  write strobe to the C RAM.
- res_addr  out  ADDR_WIDTH  C element address, i*DIM+j; valid while res_we=1.

Behaviour:
- Reset (any state) -> IDLE; i=j=k=0; all outputs 0; the rd_q pipeline flop cleared.
- All outputs are registered, from state and counters. mac_enable = rd_q, where rd_q is mem_rd delayed by one cycle to match the RAM latency.

States:
- IDLE: busy=0. If start=1 -> CLEAR with i=j=0.
- CLEAR: 1 cycle; mac_clear=1; k<=0 -> RUN.
- RUN: DIM cycles; mem_rd=1; a_addr=i*DIM+k; b_addr=k*DIM+j; k increments. After k=DIM-1 is issued -> DRAIN.
- DRAIN: 1 cycle; mem_rd=0. mac_enable is still 1 here for the k=DIM-1 data. -> WRITE.
- WRITE: 1 cycle; res_we=1; res_addr=i*DIM+j.
  - If (i,j) = (DIM-1,DIM-1) -> DONE.
  - Otherwise j increments; when j wraps from DIM-1 to 0, i increments. -> CLEAR.
- DONE: 1 cycle; done=1, busy=0 -> IDLE.

Timing:
- Cycles per element = DIM+3. Start accept to done = DIM*DIM*(DIM+3)+1, which is 113 cycles for DIM=4.
- mac_enable is high exactly DIM cycles per element, never during CLEAR or WRITE.
- a_addr, b_addr and res_addr hold their last value when their strobe is low. They are 0 after reset.

Boundary conditions:
- start while not in IDLE: ignored, with no queuing.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- abort in any busy state: next cycle is IDLE, all strobes 0, rd_q cleared, no done, no partial res_we.
- reset mid-operation: same as abort, plus counters cleared.
- Counter wrap: k, i and j use modulo-DIM arithmetic on IDX_WIDTH bits; the address concatenation {row,col} equals row*DIM+col.
- DIM=2 (IDX_WIDTH=1) must work unchanged.

Test Plan:
- Reset then idle: hold reset 3 cycles, then 10 idle cycles -> all outputs 0, busy=0.
- Full run, DIM=4:
  - Stimulus: start pulse; A = identity, B[n] = n.
  - Checks: busy rises the next cycle; done arrives exactly 113 cycles after start is sampled; 16 res_we pulses with res_addr 0..15 in order; the C RAM (modelled with a MAC reference) equals B.
- Address trace, element (1,2):
  - a_addr sequence 4,5,6,7; b_addr sequence 2,6,10,14.
  - mac_enable high in the 4 cycles that each lag mem_rd by one; mac_clear exactly 1 cycle before the first mem_rd.
- Start while busy: pulse start at cycles 20 and 50 after the first start -> identical trace to a single run; exactly one done.
- Abort mid-RUN of element 5: next cycle busy=0 and all strobes 0; no done; only 5 res_we seen. A fresh start then completes normally in 113 cycles.
- Reset mid-WRITE: assert reset in a WRITE cycle -> res_we=0 from the next cycle, state IDLE; a subsequent start produces the full 16-write sequence from res_addr 0.
